// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: the controller's
//   memory read/write codes, the arbiter FSM state encoding, and a helper
//   that word-aligns a byte address.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Memory read codes driven by the core controller (3 bits, 0 = no read).
    localparam logic [2:0] MEM_READ_NONE = 3'd0;
    localparam logic [2:0] MEM_READ_LB   = 3'd1;
    localparam logic [2:0] MEM_READ_LH   = 3'd2;
    localparam logic [2:0] MEM_READ_LW   = 3'd3;
    localparam logic [2:0] MEM_READ_LBU  = 3'd4;
    localparam logic [2:0] MEM_READ_LHU  = 3'd5;

    // Memory write codes driven by the core controller (2 bits, 0 = no write).
    localparam logic [1:0] MEM_WRITE_NONE = 2'd0;
    localparam logic [1:0] MEM_WRITE_SB   = 2'd1;
    localparam logic [1:0] MEM_WRITE_SH   = 2'd2;
    localparam logic [1:0] MEM_WRITE_SW   = 2'd3;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_ERR_D   = 2'd3
    } arb_state_e;

    // Masking (rather than slicing) keeps every address bit referenced.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
//   Purely combinational lane formatter for the data path.
//   Request side (live request):
//     req_read, req_write  - controller memory codes
//     req_off              - byte offset within the word (addr[1:0])
//     req_wdata            - right-aligned store data
//     req_err              - misaligned access or illegal/ambiguous code
//     req_we, req_be       - write enable and byte enables for the memory
//     req_wdata_rep        - store data replicated across the byte lanes
//   Load side (latched request + raw memory word):
//     ld_read, ld_off      - code and offset captured at grant
//     raw                  - raw memory word
//     ld_data              - extracted, sign/zero-extended load data (0 if
//                            no read)
// -----------------------------------------------------------------------------
module mem_lane_fmt
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  req_read,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic        req_we,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_rep,
    input  logic [2:0]  ld_read,
    input  logic [1:0]  ld_off,
    input  logic [31:0] raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output gets a default before any branch so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        req_err       = 1'b0;
        req_we        = 1'b0;
        req_be        = BE_WORD;
        req_wdata_rep = req_wdata;

        // Exactly one of read/write must be requested.
        if ((req_read != MEM_READ_NONE) == (req_write != MEM_WRITE_NONE)) begin
            req_err = 1'b1;
        end else if (req_write != MEM_WRITE_NONE) begin
            req_we = 1'b1;
            case (req_write)
                MEM_WRITE_SB: begin
                    req_be        = 4'b0001 << req_off;
                    req_wdata_rep = {4{req_wdata[7:0]}};
                end
                MEM_WRITE_SH: begin
                    req_be        = 4'b0011 << req_off;
                    req_wdata_rep = {2{req_wdata[15:0]}};
                    req_err       = req_off[0];
                end
                default: begin
                    req_err = (req_off != 2'b00);
                end
            endcase
        end else begin
            case (req_read)
                MEM_READ_LB, MEM_READ_LBU: req_err = 1'b0;
                MEM_READ_LH, MEM_READ_LHU: req_err = req_off[0];
                MEM_READ_LW:               req_err = (req_off != 2'b00);
                default:                   req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = raw[7:0];
            2'd1:    ld_byte = raw[15:8];
            2'd2:    ld_byte = raw[23:16];
            default: ld_byte = raw[31:24];
        endcase
        ld_half = ld_off[1] ? raw[31:16] : raw[15:0];

        ld_data = '0;
        case (ld_read)
            MEM_READ_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_READ_LBU: ld_data = {24'b0, ld_byte};
            MEM_READ_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_READ_LHU: ld_data = {16'b0, ld_half};
            MEM_READ_LW:  ld_data = raw;
            default:      ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch and load/store.
//   One transaction outstanding at a time; data has priority, but after
//   STARVE_MAX consecutive data grants with fetch waiting, fetch goes next.
//   Ports:
//     clk, rst_n                    - clock, async active-low reset
//     if_req/if_addr/if_gnt         - fetch request handshake
//     if_rvalid/if_rdata            - fetch completion (one-cycle pulse)
//     d_req/d_addr/d_read/d_write/d_wdata/d_gnt - data request handshake
//     d_rvalid/d_rdata/d_err        - data completion (loads, stores, errors)
//     mem_req/mem_addr/mem_we/mem_be/mem_wdata  - memory request, held until
//                                     mem_ack
//     mem_ack/mem_rdata             - memory completion and raw read word
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_read,
    input  logic [1:0]  d_write,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned       CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_win;
    logic             if_win;

    logic             req_err;
    logic             req_we;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata_rep;
    logic [31:0]      ld_data;

    logic [2:0]       ld_code_q;
    logic [1:0]       ld_off_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic             mem_we_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic             if_rvalid_q;
    logic [31:0]      if_rdata_q;
    logic             d_rvalid_q;
    logic [31:0]      d_rdata_q;
    logic             d_err_q;

    mem_lane_fmt u_lane_fmt (
        .req_read      (d_read),
        .req_write     (d_write),
        .req_off       (d_addr[1:0]),
        .req_wdata     (d_wdata),
        .req_err       (req_err),
        .req_we        (req_we),
        .req_be        (req_be),
        .req_wdata_rep (req_wdata_rep),
        .ld_read       (ld_code_q),
        .ld_off        (ld_off_q),
        .raw           (mem_rdata),
        .ld_data       (ld_data)
    );

    // Arbitration: data wins unless fetch is waiting and data has already
    // taken STARVE_MAX grants in a row.
    always_comb begin
        d_win  = 1'b0;
        if_win = 1'b0;
        if (state == ARB_IDLE) begin
            if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                d_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end
        end
    end

    // Grants are combinational; masking with rst_n keeps them low while
    // reset is asserted even though the state already reads IDLE.
    assign d_gnt  = d_win & rst_n;
    assign if_gnt = if_win & rst_n;

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (d_win) begin
                    state_next = req_err ? ARB_ERR_D : ARB_BUSY_D;
                end else if (if_win) begin
                    state_next = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_D: begin
                if (mem_ack) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_next;
    end

    // The counter only moves in IDLE; any IDLE cycle without a pending fetch
    // means fetch is not being starved, so the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (if_win || !if_req) begin
                starve_cnt <= '0;
            end else if (d_win && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Datapath registers are all reset as well: every output must read 0
    // during reset, and an abandoned transaction must leave no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_code_q   <= MEM_READ_NONE;
            ld_off_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (d_win) begin
                        ld_code_q <= d_read;
                        ld_off_q  <= d_addr[1:0];
                        if (req_err) begin
                            // No memory access; the ERR_D cycle reports it.
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= '0;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= word_addr(d_addr);
                            mem_we_q    <= req_we;
                            mem_be_q    <= req_be;
                            mem_wdata_q <= req_wdata_rep;
                        end
                    end else if (if_win) begin
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= word_addr(if_addr);
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= BE_WORD;
                        mem_wdata_q <= '0;
                    end
                end
                ARB_BUSY_IF: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        d_rvalid_q <= 1'b1;
                        // Stores latched MEM_READ_NONE, so ld_data is 0.
                        d_rdata_q  <= ld_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the RISC-V core. This supports the move from split instruction/data memories to one memory with variable latency.
- Accepts one outstanding transaction at a time and arbitrates with data priority plus a starvation guard for fetch.
- Generates word-aligned addresses, byte enables and lane-replicated write data.
- Sign-extends or zero-extends load data using the controller's memory read/write codes.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while if_req is pending; the next grant then goes to fetch.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch address, word aligned
- if_gnt  out  1  fetch accepted (combinational, IDLE only)
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  instruction word
- d_req  in  1  data request, held until granted
- d_addr  in  32  byte address
- d_read  in  3  memory read code (`MEM_READ_*`); zero means no read
- d_write  in  2  memory write code (`MEM_WRITE_*`); zero means no write
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data accepted (combinational, IDLE only)
- d_rvalid  out  1  data completion pulse, for loads and stores
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  misalignment or illegal code; valid with d_rvalid
- mem_req  out  1  memory request, held until mem_ack
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  raw memory word

Behaviour:

Reset:
- rst_n low immediately forces state IDLE, the starvation counter to 0 and every output to 0.
- An in-flight transaction is abandoned.
- A mem_ack seen in IDLE is ignored.

FSM states: IDLE, BUSY_IF, BUSY_D, ERR_D.

Arbitration (IDLE only):
- Data wins when d_req is high and either if_req is low or starve_cnt < STARVE_MAX.
- Otherwise fetch wins if if_req is high.
- The chosen requester sees its gnt high combinationally in that cycle.
- At the clock edge the block latches address, control and data, then moves to BUSY_IF or BUSY_D.

Starvation counter:
- Increments on each data grant made while if_req is high, saturating at STARVE_MAX.
- Clears on a fetch grant, and clears in any IDLE cycle with if_req low.

BUSY states:
- mem_req is registered high from the first BUSY cycle until the mem_ack cycle inclusive.
- mem_addr, mem_we, mem_be and mem_wdata come from the latched values and stay stable throughout.
- On mem_ack, the block returns to IDLE. The matching rvalid pulses in the next cycle with registered, formatted data.
- Minimum turnaround: grant in cycle 0, mem_req in cycle 1, ack in cycle 1, rvalid in cycle 2. The next grant is possible in cycle 2, the same cycle as rvalid.

Lane rules (off = d_addr[1:0]):
- Byte store: mem_be = 0001<<off, mem_wdata = {4{wdata[7:0]}}.
- Half store: mem_be = 0011<<off, mem_wdata = {2{wdata[15:0]}}.
- Word store: mem_be = 1111.
- All reads, including fetch, use mem_be = 1111 and mem_we = 0.
- Byte load: takes lane off, sign- or zero-extended per the code.
- Half load: takes the half selected by off[1].
- if_rdata is mem_rdata unmodified.

Errors:
- Error cases are: a halfword access with off[0]=1, a word access with off≠0, both d_read and d_write nonzero, or both zero.
- The request is still granted, but no memory access is issued. The FSM goes IDLE→ERR_D→IDLE.
- d_rvalid and d_err pulse in the ERR_D cycle, with d_rdata = 0.

Decomposition:
- The `MEM_READ_*` and `MEM_WRITE_*` codes stay in Defines.vh.
- Add FSM state encodings ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D and ARB_ERR_D to Defines.vh.
- One sub-module, mem_lane_fmt: purely combinational. It produces the error flag, byte enables and write replication from the request, and does load extraction and extension from the raw word.

Test Plan:
- Fetch only, if_addr=0x100, mem_ack 3 cycles after mem_req → mem_addr=0x100, mem_be=1111, if_rvalid one cycle after ack, if_rdata=mem_rdata.
- Simultaneous if_req and d_req, LW at 0x200 → d_gnt first. After d_rvalid, if_gnt in the same cycle as the return to IDLE.
- d_req held continuously with if_req pending, STARVE_MAX=4 → exactly 4 data grants, then if_gnt, then the counter restarts.
- SB at 0x203 with wdata=0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1. LB at 0x203 with mem_rdata=0x80xxxxxx → d_rdata=0xFFFFFF80; LBU → 0x00000080.
- LH at 0x201 → no mem_req, d_rvalid=1 and d_err=1 one cycle after grant. LHU at 0x202 with mem_rdata=0xBEEF0000 → d_rdata=0x0000BEEF.
- rst_n low while in BUSY_D with mem_req high → mem_req=0 immediately. A later mem_ack produces no rvalid, and the next request arbitrates normally.
